// File: rtl/snake_pkg.sv
// Shared cell codes, direction encoding and FSM states for the snake game logic.
package snake_pkg;

  localparam int CELL_EMPTY = 0;
  localparam int CELL_BODY  = 1;
  localparam int CELL_FOOD  = 2;
  localparam int CELL_WALL  = 3;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_UP    = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_WRITE_HEAD,
    ST_ERASE_TAIL,
    ST_DEAD
  } state_e;

  // Opposite directions differ only in bit 1.
  function automatic logic is_opposite(dir_e a, dir_e b);
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Ring buffer of snake body cells: push at head, pop at tail.
module snake_body_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int XW    = 7,
  parameter int YW    = 6,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [XW-1:0] push_x,
  input  logic [YW-1:0] push_y,
  input  logic          pop,
  output logic [XW-1:0] tail_x,
  output logic [YW-1:0] tail_y,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [XW+YW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {push_x, push_y};
  end

  assign {tail_x, tail_y} = mem_q[rd_q];
  assign count            = cnt_q;

endmodule

// File: rtl/snake_mover.sv
// Snake game step engine driving the play-area grid RAM port.
// Define SNAKE_WRAP_EN to wrap at grid edges instead of dying.
module snake_mover
  import snake_pkg::*;
#(
  parameter int WIDTH     = 80,
  parameter int HEIGHT    = 60,
  parameter int BIT_DEPTH = 3,
  parameter int MAX_LEN   = 256,
  parameter int START_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [1:0]                   direction,
  input  logic                         grow,
  output logic [$clog2(WIDTH)-1:0]     grid_x,
  output logic [$clog2(HEIGHT)-1:0]    grid_y,
  output logic                         grid_we,
  output logic [BIT_DEPTH-1:0]         grid_wdata,
  input  logic [BIT_DEPTH-1:0]         grid_rdata,
  output logic                         busy,
  output logic                         game_over,
  output logic [$clog2(MAX_LEN+1)-1:0] length
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = $clog2(MAX_LEN+1);

  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH-1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT-1);
  localparam logic [XW-1:0] X_TAIL0 = XW'(WIDTH/2-START_LEN+1);
  localparam logic [YW-1:0] Y_MID   = YW'(HEIGHT/2);
  localparam logic [LW-1:0] L_START = LW'(START_LEN);
  localparam logic [LW-1:0] L_ILAST = LW'(START_LEN-1);
  localparam logic [LW-1:0] L_MAX   = LW'(MAX_LEN);

  localparam logic [BIT_DEPTH-1:0] C_EMPTY = BIT_DEPTH'(CELL_EMPTY);
  localparam logic [BIT_DEPTH-1:0] C_BODY  = BIT_DEPTH'(CELL_BODY);
  localparam logic [BIT_DEPTH-1:0] C_FOOD  = BIT_DEPTH'(CELL_FOOD);
  localparam logic [BIT_DEPTH-1:0] C_WALL  = BIT_DEPTH'(CELL_WALL);

`ifdef SNAKE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  state_e state_q, state_d;

  logic [XW-1:0]        cx_q, cx_d;
  logic [YW-1:0]        cy_q, cy_d;
  logic [LW-1:0]        init_q, init_d;
  logic [XW-1:0]        head_x_q, head_x_d;
  logic [YW-1:0]        head_y_q, head_y_d;
  logic [XW-1:0]        nh_x_q, nh_x_d;
  logic [YW-1:0]        nh_y_q, nh_y_d;
  dir_e                 dir_q, dir_d;
  logic                 grow_pend_q, grow_pend_d;
  logic                 grow_now_q, grow_now_d;
  logic [XW-1:0]        tail_x_q, tail_x_d;
  logic [YW-1:0]        tail_y_q, tail_y_d;
  logic [LW-1:0]        length_q, length_d;
  logic [XW-1:0]        grid_x_q, grid_x_d;
  logic [YW-1:0]        grid_y_q, grid_y_d;
  logic                 grid_we_q, grid_we_d;
  logic [BIT_DEPTH-1:0] grid_wdata_q, grid_wdata_d;
  logic                 busy_q, busy_d;
  logic                 game_over_q, game_over_d;

  logic          push, pop;
  logic [XW-1:0] push_x, fifo_tail_x, init_x;
  logic [YW-1:0] push_y, fifo_tail_y;
  logic [LW-1:0] fifo_count;

  dir_e          req_dir, new_dir;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          off_edge;
  logic          hit;

  snake_body_fifo #(
    .DEPTH (MAX_LEN),
    .XW    (XW),
    .YW    (YW),
    .CW    (LW)
  ) u_body (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .push_x (push_x),
    .push_y (push_y),
    .pop    (pop),
    .tail_x (fifo_tail_x),
    .tail_y (fifo_tail_y),
    .count  (fifo_count)
  );

  assign init_x = X_TAIL0 + XW'(init_q);
  assign hit    = (grid_rdata == C_BODY) || (grid_rdata == C_WALL);

  // Candidate next head for the direction a tick would commit to.
  always_comb begin
    req_dir  = dir_e'(direction);
    new_dir  = is_opposite(req_dir, dir_q) ? dir_q : req_dir;
    step_x   = head_x_q;
    step_y   = head_y_q;
    off_edge = 1'b0;
    unique case (new_dir)
      DIR_RIGHT:
        if (head_x_q == X_LAST) begin
          off_edge = 1'b1;
          step_x   = '0;
        end else step_x = head_x_q + 1'b1;
      DIR_LEFT:
        if (head_x_q == '0) begin
          off_edge = 1'b1;
          step_x   = X_LAST;
        end else step_x = head_x_q - 1'b1;
      DIR_DOWN:
        if (head_y_q == Y_LAST) begin
          off_edge = 1'b1;
          step_y   = '0;
        end else step_y = head_y_q + 1'b1;
      DIR_UP:
        if (head_y_q == '0) begin
          off_edge = 1'b1;
          step_y   = Y_LAST;
        end else step_y = head_y_q - 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR:
        if (cx_q == X_LAST && cy_q == Y_LAST) state_d = ST_INIT;
      ST_INIT:
        if (init_q == L_ILAST) state_d = ST_IDLE;
      ST_IDLE:
        if (tick) state_d = (off_edge && !WRAP) ? ST_DEAD : ST_READ;
      ST_READ:       state_d = ST_CHECK;
      ST_CHECK:      state_d = hit ? ST_DEAD : ST_WRITE_HEAD;
      ST_WRITE_HEAD: state_d = grow_now_q ? ST_IDLE : ST_ERASE_TAIL;
      ST_ERASE_TAIL: state_d = ST_IDLE;
      ST_DEAD:       state_d = ST_DEAD;
    endcase
  end

  always_comb begin
    cx_d         = cx_q;
    cy_d         = cy_q;
    init_d       = init_q;
    head_x_d     = head_x_q;
    head_y_d     = head_y_q;
    nh_x_d       = nh_x_q;
    nh_y_d       = nh_y_q;
    dir_d        = dir_q;
    grow_pend_d  = grow_pend_q | grow;
    grow_now_d   = grow_now_q;
    tail_x_d     = tail_x_q;
    tail_y_d     = tail_y_q;
    length_d     = length_q;
    grid_x_d     = grid_x_q;
    grid_y_d     = grid_y_q;
    grid_we_d    = 1'b0;
    grid_wdata_d = grid_wdata_q;
    push         = 1'b0;
    pop          = 1'b0;
    push_x       = nh_x_q;
    push_y       = nh_y_q;
    unique case (state_q)
      ST_CLEAR: begin
        grid_x_d     = cx_q;
        grid_y_d     = cy_q;
        grid_we_d    = 1'b1;
        grid_wdata_d = C_EMPTY;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          cy_d = cy_q + 1'b1;
        end else cx_d = cx_q + 1'b1;
      end
      ST_INIT: begin
        grid_x_d     = init_x;
        grid_y_d     = Y_MID;
        grid_we_d    = 1'b1;
        grid_wdata_d = C_BODY;
        push         = 1'b1;
        push_x       = init_x;
        push_y       = Y_MID;
        head_x_d     = init_x;
        head_y_d     = Y_MID;
        init_d       = init_q + 1'b1;
        dir_d        = DIR_RIGHT;
        if (init_q == L_ILAST) length_d = L_START;
      end
      ST_IDLE:
        if (tick) begin
          dir_d    = new_dir;
          nh_x_d   = step_x;
          nh_y_d   = step_y;
          grid_x_d = step_x;
          grid_y_d = step_y;
        end
      ST_CHECK:
        if (!hit) begin
          // Decide growth now so a full buffer can pop and push together.
          grow_now_d   = (grow_pend_q || grid_rdata == C_FOOD)
                         && fifo_count != L_MAX;
          grow_pend_d  = grow;
          push         = 1'b1;
          head_x_d     = nh_x_q;
          head_y_d     = nh_y_q;
          grid_x_d     = nh_x_q;
          grid_y_d     = nh_y_q;
          grid_we_d    = 1'b1;
          grid_wdata_d = C_BODY;
          if (!grow_now_d) begin
            pop      = 1'b1;
            tail_x_d = fifo_tail_x;
            tail_y_d = fifo_tail_y;
          end
        end
      ST_WRITE_HEAD:
        if (grow_now_q) length_d = length_q + 1'b1;
        else begin
          grid_x_d     = tail_x_q;
          grid_y_d     = tail_y_q;
          grid_we_d    = 1'b1;
          grid_wdata_d = C_EMPTY;
        end
      ST_READ, ST_ERASE_TAIL, ST_DEAD: ;
    endcase
    busy_d      = !(state_d == ST_IDLE || state_d == ST_DEAD);
    game_over_d = state_d == ST_DEAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q         <= '0;
      cy_q         <= '0;
      init_q       <= '0;
      head_x_q     <= '0;
      head_y_q     <= '0;
      nh_x_q       <= '0;
      nh_y_q       <= '0;
      dir_q        <= DIR_RIGHT;
      grow_pend_q  <= 1'b0;
      grow_now_q   <= 1'b0;
      tail_x_q     <= '0;
      tail_y_q     <= '0;
      length_q     <= '0;
      grid_x_q     <= '0;
      grid_y_q     <= '0;
      grid_we_q    <= 1'b0;
      grid_wdata_q <= '0;
      busy_q       <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      init_q       <= init_d;
      head_x_q     <= head_x_d;
      head_y_q     <= head_y_d;
      nh_x_q       <= nh_x_d;
      nh_y_q       <= nh_y_d;
      dir_q        <= dir_d;
      grow_pend_q  <= grow_pend_d;
      grow_now_q   <= grow_now_d;
      tail_x_q     <= tail_x_d;
      tail_y_q     <= tail_y_d;
      length_q     <= length_d;
      grid_x_q     <= grid_x_d;
      grid_y_q     <= grid_y_d;
      grid_we_q    <= grid_we_d;
      grid_wdata_q <= grid_wdata_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
    end
  end

  assign grid_x     = grid_x_q;
  assign grid_y     = grid_y_q;
  assign grid_we    = grid_we_q;
  assign grid_wdata = grid_wdata_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign length     = length_q;

endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover against a behavioural grid RAM.
module tb_snake_mover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       grow = 1'b0;
  logic [1:0] direction = 2'd0;
  logic [6:0] grid_x;
  logic [5:0] grid_y;
  logic       grid_we;
  logic [2:0] grid_wdata;
  logic [2:0] grid_rdata;
  logic       busy;
  logic       game_over;
  logic [8:0] length;

  logic [2:0] grid [0:127][0:63];
  logic       poke_en = 1'b0;
  logic [6:0] poke_x = '0;
  logic [5:0] poke_y = '0;
  logic [2:0] poke_v = '0;

  typedef struct packed {
    logic [6:0] x;
    logic [5:0] y;
    logic [2:0] v;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  snake_mover dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .direction  (direction),
    .grow       (grow),
    .grid_x     (grid_x),
    .grid_y     (grid_y),
    .grid_we    (grid_we),
    .grid_wdata (grid_wdata),
    .grid_rdata (grid_rdata),
    .busy       (busy),
    .game_over  (game_over),
    .length     (length)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (grid_we) grid[grid_x][grid_y] <= grid_wdata;
    if (poke_en) grid[poke_x][poke_y] <= poke_v;
    grid_rdata <= grid[grid_x][grid_y];
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic expect_wr(input int x, input int y, input int v);
    wr_t e;
    e.x = x[6:0];
    e.y = y[5:0];
    e.v = v[2:0];
    exp_q.push_back(e);
  endtask

  // One clock; any grid write seen is popped against the scoreboard.
  task automatic sb_cycle();
    @(negedge clk);
    if (grid_we) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got (%0d,%0d)=%0d",
                 grid_x, grid_y, grid_wdata);
      end else begin
        e = exp_q.pop_front();
        if (grid_x !== e.x || grid_y !== e.y || grid_wdata !== e.v) begin
          errors++;
          $display("FAIL write got (%0d,%0d)=%0d want (%0d,%0d)=%0d",
                   grid_x, grid_y, grid_wdata, e.x, e.y, e.v);
        end
      end
    end
  endtask

  task automatic do_reset(output int cyc);
    rst_n = 1'b0;
    sb_cycle();
    sb_cycle();
    for (int y = 0; y < 60; y++)
      for (int x = 0; x < 80; x++)
        expect_wr(x, y, 0);
    for (int i = 0; i < 4; i++) expect_wr(37 + i, 30, 1);
    rst_n = 1'b1;
    cyc = 0;
    do begin
      sb_cycle();
      cyc++;
    end while (busy && cyc < 6000);
  endtask

  task automatic do_tick(input logic [1:0] d, input logic g,
                         output int cyc, output logic [6:0] rx,
                         output logic [5:0] ry, output logic rwe);
    direction = d;
    tick = 1'b1;
    grow = g;
    sb_cycle();
    tick = 1'b0;
    grow = 1'b0;
    rx = grid_x;
    ry = grid_y;
    rwe = grid_we;
    cyc = 1;
    while (busy && cyc < 50) begin
      sb_cycle();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    sb_cycle();
    checks++;
    if ({grid_x, grid_y, grid_we, grid_wdata} !== 17'd0) begin
      errors++;
      $display("FAIL reset_grid got x=%0d y=%0d we=%0d wd=%0d want 0",
               grid_x, grid_y, grid_we, grid_wdata);
    end
    checks++;
    if (busy !== 1'b1 || game_over !== 1'b0 || length !== 9'd0) begin
      errors++;
      $display("FAIL reset_status got busy=%0d go=%0d len=%0d want 1/0/0",
               busy, game_over, length);
    end
    do_reset(c);
    checks++;
    if (c !== 4804) begin
      errors++;
      $display("FAIL init_latency got %0d want 4804", c);
    end
    checks++;
    if (length !== 9'd4) begin
      errors++;
      $display("FAIL init_length got %0d want 4", length);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL init_writes_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_step();
    int c;
    logic [6:0] rx;
    logic [5:0] ry;
    logic rwe;
    expect_wr(41, 30, 1);
    expect_wr(37, 30, 0);
    do_tick(2'd0, 1'b0, c, rx, ry, rwe);
    checks++;
    if (rx !== 7'd41 || ry !== 6'd30 || rwe !== 1'b0) begin
      errors++;
      $display("FAIL step_read got (%0d,%0d) we=%0d want (41,30) we=0",
               rx, ry, rwe);
    end
    checks++;
    if (c !== 5) begin
      errors++;
      $display("FAIL step_cycles got %0d want 5", c);
    end
    checks++;
    if (length !== 9'd4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL step_state got len=%0d left=%0d want 4/0",
               length, exp_q.size());
    end
  endtask

  task automatic test_grow_food();
    int c;
    logic [6:0] rx;
    logic [5:0] ry;
    logic rwe;
    poke_x = 7'd42;
    poke_y = 6'd30;
    poke_v = 3'd2;
    poke_en = 1'b1;
    sb_cycle();
    poke_en = 1'b0;
    expect_wr(42, 30, 1);
    do_tick(2'd0, 1'b0, c, rx, ry, rwe);
    checks++;
    if (c !== 4) begin
      errors++;
      $display("FAIL food_cycles got %0d want 4", c);
    end
    checks++;
    if (length !== 9'd5 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL food_state got len=%0d left=%0d want 5/0",
               length, exp_q.size());
    end
  endtask

  task automatic test_opposite();
    int c;
    logic [6:0] rx;
    logic [5:0] ry;
    logic rwe;
    expect_wr(43, 30, 1);
    expect_wr(38, 30, 0);
    do_tick(2'd2, 1'b0, c, rx, ry, rwe);
    checks++;
    if (rx !== 7'd43 || ry !== 6'd30 || c !== 5) begin
      errors++;
      $display("FAIL opposite got (%0d,%0d) cyc=%0d want (43,30) cyc=5",
               rx, ry, c);
    end
    checks++;
    if (length !== 9'd5 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL opposite_state got len=%0d left=%0d want 5/0",
               length, exp_q.size());
    end
  endtask

  task automatic test_grow_pulse();
    int c;
    logic [6:0] rx;
    logic [5:0] ry;
    logic rwe;
    expect_wr(44, 30, 1);
    do_tick(2'd0, 1'b1, c, rx, ry, rwe);
    checks++;
    if (c !== 4 || length !== 9'd6) begin
      errors++;
      $display("FAIL grow_pulse got cyc=%0d len=%0d want 4/6", c, length);
    end
  endtask

  task automatic test_collision();
    int c;
    logic [6:0] rx;
    logic [5:0] ry;
    logic rwe;
    expect_wr(44, 31, 1);
    expect_wr(39, 30, 0);
    do_tick(2'd1, 1'b0, c, rx, ry, rwe);
    expect_wr(43, 31, 1);
    expect_wr(40, 30, 0);
    do_tick(2'd2, 1'b0, c, rx, ry, rwe);
    checks++;
    if (c !== 5 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL turn got cyc=%0d left=%0d want 5/0", c, exp_q.size());
    end
    do_tick(2'd3, 1'b0, c, rx, ry, rwe);
    checks++;
    if (rx !== 7'd43 || ry !== 6'd30 || c !== 3) begin
      errors++;
      $display("FAIL collide got (%0d,%0d) cyc=%0d want (43,30) cyc=3",
               rx, ry, c);
    end
    checks++;
    if (game_over !== 1'b1 || busy !== 1'b0 || length !== 9'd6) begin
      errors++;
      $display("FAIL collide_state got go=%0d busy=%0d len=%0d want 1/0/6",
               game_over, busy, length);
    end
    do_tick(2'd0, 1'b0, c, rx, ry, rwe);
    for (int i = 0; i < 6; i++) sb_cycle();
    checks++;
    if (c !== 1 || game_over !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dead_tick got cyc=%0d go=%0d busy=%0d want 1/1/0",
               c, game_over, busy);
    end
  endtask

  task automatic test_edge();
    int c;
    int total;
    logic [6:0] rx;
    logic [5:0] ry;
    logic rwe;
    do_reset(c);
    checks++;
    if (c !== 4804 || game_over !== 1'b0 || length !== 9'd4) begin
      errors++;
      $display("FAIL rereset got cyc=%0d go=%0d len=%0d want 4804/0/4",
               c, game_over, length);
    end
    total = 0;
    for (int i = 0; i < 39; i++) begin
      expect_wr(41 + i, 30, 1);
      expect_wr(37 + i, 30, 0);
      do_tick(2'd0, 1'b0, c, rx, ry, rwe);
      total += c;
    end
    checks++;
    if (total !== 195 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL run_right got cyc=%0d left=%0d want 195/0",
               total, exp_q.size());
    end
`ifdef SNAKE_WRAP_EN
    expect_wr(0, 30, 1);
    expect_wr(76, 30, 0);
    do_tick(2'd0, 1'b0, c, rx, ry, rwe);
    checks++;
    if (rx !== 7'd0 || c !== 5 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL wrap got x=%0d cyc=%0d go=%0d want 0/5/0",
               rx, c, game_over);
    end
`else
    do_tick(2'd0, 1'b0, c, rx, ry, rwe);
    checks++;
    if (c !== 1 || game_over !== 1'b1 || rwe !== 1'b0) begin
      errors++;
      $display("FAIL edge_dead got cyc=%0d go=%0d we=%0d want 1/1/0",
               c, game_over, rwe);
    end
`endif
    for (int i = 0; i < 4; i++) sb_cycle();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL edge_writes_left got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_grow_food();
    test_opposite();
    test_grow_pulse();
    test_collision();
    test_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
